uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with configurable frame format (data width, parity, stop bits) and an input FIFO behind a valid/ready handshake. It serialises queued words LSB-first onto a single TX line and sends back-to-back frames without idle gaps while data is queued. It sits between on-chip producers (CPU, debug logic) and the board UART pin.

## Interface
- FREQ, 50_000_000: clock frequency, Hz.
- RATE, 115_200: baud rate; CNT_MAX = FREQ/RATE-1, integer division; each bit lasts CNT_MAX+1 cycles.
- DATA_BITS, 8: payload width, legal values 5..9.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: legal values 1 or 2.
- DEPTH, 4: FIFO entries, power of two, at least 2.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_data  in  DATA_BITS  word to transmit.
- i_valid  in  1  i_data is valid this cycle.
- o_ready  out  1  FIFO not full; reset 1.
- o_tx  out  1  serial line, registered; reset 1 (idle/mark).
- o_busy  out  1  FIFO non-empty or frame in progress; reset 0.

## Operation
- Accept: i_valid && o_ready at an edge writes i_data to the FIFO. i_valid while !o_ready is ignored; producer holds. o_ready is !full and does not depend on a same-cycle pop.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START when the FIFO is non-empty: pop, load shifter, clear baud counter and bit index.
  - START -> DATA after 1 bit time.
  - DATA -> PAR after DATA_BITS bit times if PARITY != 0, else DATA -> STOP. Shift right each bit; o_tx = shifter[0].
  - PAR -> STOP after 1 bit time.
  - STOP: STOP_BITS bit times. At the end, go directly to START (with a pop) if the FIFO is non-empty, else to IDLE.
- Line levels: start bit 0, data LSB first, stop bits 1.
- Parity bit: even = XOR of data bits; odd = its inverse. It is computed from the word at load time.
- Baud counter: runs only outside IDLE; counts 0..CNT_MAX; wraps to 0 at the end of each bit. Width is $clog2(CNT_MAX+1).
- Bit index: $clog2(DATA_BITS+1) bits. It also counts the second stop bit.
- Reset mid-frame: at the reset edge o_tx returns to 1, FSM goes to IDLE, FIFO is flushed, counters are cleared, o_busy goes to 0. No partial frame resumes.

## Timing
- Word accepted at edge k into an empty, idle block: FIFO is non-empty after edge k, pop at edge k+1, o_tx = 0 from edge k+1.
- Frame length: (CNT_MAX+1)·(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the edge right after the last stop-bit cycle, with zero idle cycles.
- o_ready falls the edge after the DEPTH-th unpopped write. It rises the edge after a pop from a full FIFO.
- o_busy rises with the accepting edge. It falls at the edge the FSM returns to IDLE with the FIFO empty.

## Structure
- Package uart_pkg holds:
  - parity constants PARITY_NONE/EVEN/ODD;
  - the FSM state encoding;
  - a frame-length helper function shared with the future uart_rx.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty, synchronous active-low reset) is instantiated once and is reusable.
- Parameter legality is checked at elaboration. Illegal DATA_BITS, PARITY, STOP_BITS or DEPTH stops elaboration with an error.

## Test plan
Bench: FREQ=1000, RATE=100, so 10 cycles per bit.
- 8N1, push 0xA5 -> o_tx: 0, then 1,0,1,0,0,1,0,1, then 1; 100 cycles total; o_busy high for exactly that window.
- 8E1 0xA5 -> parity bit 0. 8O1 0xA5 -> parity bit 1. Each frame 110 cycles.
- 7E2, push 0x43 -> data 1,1,0,0,0,0,1; parity 1; two stop bits; 110 cycles.
- DEPTH=4, push 6 words on consecutive cycles with i_valid held -> o_ready drops after the 4th unpopped write; all 6 frames sent back-to-back with no idle cycle; order preserved.
- rst_n low for 1 cycle in mid-DATA with 2 words queued -> o_tx=1 the next edge; o_ready=1; o_busy=0; nothing transmitted afterwards.
- Push at the edge the FIFO goes full and a pop occurs -> write rejected (o_ready was 0); the word is accepted one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encoding and frame-length helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_e;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_cycles(input int cnt_max, input int data_bits,
                                        input int parity, input int stop_bits);
        return (cnt_max + 1) * (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop and full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted operations only.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers; reset flushes the contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with configurable frame format
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FREQ      = 50_000_000,
    parameter int RATE      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int CNT_MAX = FREQ / RATE - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int IW      = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
    end

    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty, pop;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end, load;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_valid),
        .wdata (i_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_ready = !fifo_full;
    assign o_tx    = tx_q;
    assign o_busy  = !fifo_empty || (state_q != ST_IDLE);
    assign bit_end = (cnt_q == CW'(CNT_MAX));

    // Next-state logic: bit timing, shifting and frame sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;
        pop     = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                            idx_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Starting a frame: pop the head word and latch its parity now.
        if (load) begin
            pop     = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = fifo_rdata;
            par_d   = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
        end
    end

    // State and registered line output; reset forces the line idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
